// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM write port and one read port among NREQ requesters,
// with a built-in zero-fill sequencer that blocks all requesters while it runs.
module ram_arbiter #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8,
   parameter int NREQ   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   init,
   output logic                   init_busy,
   output logic                   init_done,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        wr,
   input  logic [NREQ*AWIDTH-1:0] addr,
   input  logic [NREQ*DWIDTH-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DWIDTH-1:0]      rsp_data,
   output logic                   ram_we,
   output logic [AWIDTH-1:0]      ram_waddr,
   output logic [DWIDTH-1:0]      ram_wdata,
   output logic                   ram_re,
   output logic [AWIDTH-1:0]      ram_raddr,
   input  logic [DWIDTH-1:0]      ram_rdata
);

   localparam int SIZE = 2 ** AWIDTH;
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, INIT} state_t;

   state_t            state;
   state_t            state_nx;
   logic [AWIDTH-1:0] cnt;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     ptr_nx;
   logic [PW-1:0]     win;
   logic [PW-1:0]     idx;
   logic              found;
   logic              gnt_en;
   logic [NREQ-1:0]   win_oh;

   // First requester found searching upward from ptr, wrapping at NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign gnt_en    = (state == IDLE) && !rst && found;
   assign win_oh    = NREQ'(1) << win;
   assign gnt       = gnt_en ? win_oh : '0;
   assign ptr_nx    = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
   assign init_busy = (state == INIT);

   always_comb begin
      state_nx  = state;
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      ram_re    = 1'b0;
      ram_raddr = '0;
      unique case (state)
         IDLE: begin
            if (init) state_nx = INIT;
            if (gnt_en) begin
               if (wr[win]) begin
                  ram_we    = 1'b1;
                  ram_waddr = addr[win*AWIDTH +: AWIDTH];
                  ram_wdata = wdata[win*DWIDTH +: DWIDTH];
               end else begin
                  ram_re    = 1'b1;
                  ram_raddr = addr[win*AWIDTH +: AWIDTH];
               end
            end
         end
         INIT: begin
            ram_we    = !rst;
            ram_waddr = cnt;
            if (cnt == AWIDTH'(SIZE - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         init_done <= (state == INIT) && (state_nx == IDLE);
         rsp_valid <= '0;
         if (state == INIT) cnt <= cnt + 1'b1;
         else if (init)     cnt <= '0;
         if (gnt_en) begin
            ptr <= ptr_nx;
            if (!wr[win]) begin
               rsp_valid <= win_oh;
               rsp_data  <= ram_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: grants are checked inline, read responses
// are matched by a queue-based monitor against hand-computed values.
module tb_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NR = 4;

   typedef struct {
      logic [NR-1:0] v;
      logic [DW-1:0] d;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            init;
   logic            init_busy;
   logic            init_done;
   logic [NR-1:0]   req;
   logic [NR-1:0]   wr;
   logic [NR*AW-1:0] addr;
   logic [NR*DW-1:0] wdata;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [DW-1:0]   ram_wdata;
   logic            ram_re;
   logic [AW-1:0]   ram_raddr;
   logic [DW-1:0]   ram_rdata;

   logic [DW-1:0]   mem [16];
   logic [DW-1:0]   vals [4];
   exp_t            q[$];
   int              asserts;
   int              fails;

   ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR)) dut (
      .clk(clk), .rst(rst), .init(init),
      .init_busy(init_busy), .init_done(init_done),
      .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, asynchronous read
   always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
   assign ram_rdata = mem[ram_raddr];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid !== '0) begin
         exp_t e;
         if (q.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL unexpected_rsp: got valid %b with no read pending", rsp_valid);
         end else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
            chk("rsp_data", 32'(rsp_data), 32'(e.d));
         end
      end
   end

   task automatic setr(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      wr[i]            = w;
      addr[i*AW +: AW] = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic push_rd(input logic [NR-1:0] g, input logic [DW-1:0] d);
      exp_t e;
      if ((g & ~wr) != '0) begin
         e.v = g;
         e.d = d;
         q.push_back(e);
      end
   endtask

   // One arbitration cycle: check grant, queue any expected read response
   task automatic cyc(input string n, input logic [NR-1:0] g, input logic [DW-1:0] d);
      @(negedge clk);
      chk(n, 32'(gnt), 32'(g));
      push_rd(g, d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit got;
      asserts = 0;
      fails   = 0;
      vals[0] = 8'h10;
      vals[1] = 8'h21;
      vals[2] = 8'h32;
      vals[3] = 8'h43;
      init  = 1'b0;
      req   = '1;
      wr    = '0;
      addr  = '0;
      wdata = '0;
      rst   = 1'b1;
      @(negedge clk);
      chk("gnt_in_rst", 32'(gnt), 32'h0);
      chk("re_in_rst", 32'(ram_re), 32'h0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_init_busy", 32'(init_busy), 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      @(posedge clk);
      #1;

      // preload addrs 0..3 through requester 0
      req = 4'b0001;
      for (int j = 0; j < 4; j++) begin
         setr(0, 1'b1, AW'(j), vals[j]);
         cyc("preload_gnt", 4'b0001, 8'h00);
      end
      req = '0;

      // round robin under full read load from a fresh pointer
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NR; i++) setr(i, 1'b0, AW'(i), 8'h00);
      for (int n = 0; n < 8; n++)
         cyc("rr_gnt", 4'b0001 << (n % 4), vals[n % 4]);
      req = '0;

      // write by 2 then read by 0 of the same address
      req = 4'b0100;
      setr(2, 1'b1, 4'd5, 8'hA5);
      cyc("wr2_gnt", 4'b0100, 8'h00);
      req = 4'b0001;
      setr(0, 1'b0, 4'd5, 8'h00);
      cyc("rd0_gnt", 4'b0001, 8'hA5);

      // ptr is now 1: index 3 must win over 0, then 0 next
      req = 4'b1001;
      setr(3, 1'b0, 4'd3, 8'h00);
      setr(0, 1'b0, 4'd0, 8'h00);
      cyc("skip_gnt3", 4'b1000, vals[3]);
      cyc("skip_gnt0", 4'b0001, vals[0]);
      req = '0;

      // fill with FF, then zero-fill with requester 1 held
      req = 4'b0010;
      for (int j = 0; j < 16; j++) begin
         setr(1, 1'b1, AW'(j), 8'hFF);
         cyc("fill_gnt", 4'b0010, 8'h00);
      end
      init = 1'b1;
      setr(1, 1'b1, 4'd9, 8'hFF);
      cyc("init_wr_gnt", 4'b0010, 8'h00);
      init = 1'b0;
      setr(1, 1'b0, 4'd9, 8'h00);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("zf_busy", 32'(init_busy), 32'h1);
         chk("zf_gnt", 32'(gnt), 32'h0);
         chk("zf_we", 32'(ram_we), 32'h1);
         chk("zf_waddr", 32'(ram_waddr), 32'(k));
         chk("zf_wdata", 32'(ram_wdata), 32'h0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("zf_done", 32'(init_done), 32'h1);
      chk("zf_busy_off", 32'(init_busy), 32'h0);
      chk("zf_done_gnt", 32'(gnt), 32'h2);
      push_rd(4'b0010, 8'h00);
      @(posedge clk);
      #1;
      setr(1, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      chk("zf_done_pulse", 32'(init_done), 32'h0);
      chk("zf_rd0_gnt", 32'(gnt), 32'h2);
      push_rd(4'b0010, 8'h00);
      @(posedge clk);
      #1;
      setr(1, 1'b0, 4'd15, 8'h00);
      cyc("zf_rd15_gnt", 4'b0010, 8'h00);
      req = '0;

      // init coincident with a write request
      init = 1'b1;
      req  = 4'b0100;
      setr(2, 1'b1, 4'd3, 8'h3C);
      cyc("coinc_gnt", 4'b0100, 8'h00);
      init = 1'b0;
      req  = '0;
      @(negedge clk);
      chk("coinc_busy", 32'(init_busy), 32'h1);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (init_done) got = 1'b1;
      end
      chk("coinc_done_seen", 32'(got), 32'h1);
      @(posedge clk);
      #1;
      req = 4'b0100;
      setr(2, 1'b0, 4'd3, 8'h00);
      cyc("coinc_rd_gnt", 4'b0100, 8'h00);
      req = '0;

      // reset while cnt==7; ptr is 3 going in
      init = 1'b1;
      cyc("mid_init_start", 4'b0000, 8'h00);
      init = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("mid_waddr", 32'(ram_waddr), 32'(k));
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mid_cnt7", 32'(ram_waddr), 32'h7);
      chk("mid_we_forced", 32'(ram_we), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_busy", 32'(init_busy), 32'h0);
      chk("mid_no_done", 32'(init_done), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_no_done2", 32'(init_done), 32'h0);
      @(posedge clk);
      #1;
      req = 4'b1111;
      for (int i = 0; i < NR; i++) setr(i, 1'b0, AW'(i), 8'h00);
      cyc("mid_ptr0", 4'b0001, 8'h00);
      req = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
